// File: rtl/l2_msg_sched.sv
// Message scheduler ahead of the L2 pipeline: arbitrates msg1/msg3 into one held
// in-flight message and queues nonzero pipeline responses onto the msg2 channel.
module l2_msg_sched #(
    parameter int DATA_W     = 64,
    parameter int TAG_W      = 26,
    parameter int SRC_W      = 6,
    parameter int TYPE_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              msg1_valid,
    output logic              msg1_ready,
    input  logic [TYPE_W-1:0] msg1_type,
    input  logic [SRC_W-1:0]  msg1_source,
    input  logic [TAG_W-1:0]  msg1_tag,
    input  logic [DATA_W-1:0] msg1_data,
    input  logic              msg3_valid,
    output logic              msg3_ready,
    input  logic [TYPE_W-1:0] msg3_type,
    input  logic [SRC_W-1:0]  msg3_source,
    input  logic [TAG_W-1:0]  msg3_tag,
    input  logic [DATA_W-1:0] msg3_data,
    output logic              pipe_valid,
    input  logic              pipe_ready,
    output logic              pipe_chan,
    output logic [TYPE_W-1:0] pipe_type,
    output logic [SRC_W-1:0]  pipe_source,
    output logic [TAG_W-1:0]  pipe_tag,
    output logic [DATA_W-1:0] pipe_data,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [TYPE_W-1:0] rsp_type,
    output logic              msg2_valid,
    input  logic              msg2_ready,
    output logic [TYPE_W-1:0] msg2_type,
    output logic [7:0]        msg2_stall_cnt,
    output logic [1:0]        sched_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        starve_cnt;
    logic              starve_hit;
    logic              take_msg;
    logic              pipe_fire;
    logic              rsp_fire;
    logic              push;
    logic              pop;
    logic [1:0]        q_count;
    logic [TYPE_W-1:0] q_head;
    logic [TYPE_W-1:0] q_tail;

    assign starve_hit = (starve_cnt == 4'(STARVE_MAX));
    assign take_msg   = msg1_ready | msg3_ready;
    assign pipe_fire  = pipe_valid & pipe_ready;
    assign rsp_fire   = rsp_valid & rsp_ready;
    assign push       = rsp_fire && (rsp_type != '0);
    assign pop        = msg2_valid & msg2_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (take_msg)  state_next = ISSUE;
            ISSUE:    if (pipe_fire) state_next = WAIT_RSP;
            WAIT_RSP: if (rsp_fire)  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // msg3 normally wins a tie; msg1 only wins once it has been passed over STARVE_MAX times.
    always_comb begin
        msg1_ready = 1'b0;
        msg3_ready = 1'b0;
        pipe_valid = 1'b0;
        rsp_ready  = 1'b0;
        case (state)
            IDLE: begin
                msg1_ready = msg1_valid && (!msg3_valid || starve_hit);
                msg3_ready = msg3_valid && !(msg1_valid && starve_hit);
            end
            ISSUE:    pipe_valid = 1'b1;
            WAIT_RSP: rsp_ready  = (q_count < 2'd2);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt  <= '0;
            pipe_chan   <= 1'b0;
            pipe_type   <= '0;
            pipe_source <= '0;
            pipe_tag    <= '0;
            pipe_data   <= '0;
        end else if (msg1_ready) begin
            starve_cnt  <= '0;
            pipe_chan   <= 1'b0;
            pipe_type   <= msg1_type;
            pipe_source <= msg1_source;
            pipe_tag    <= msg1_tag;
            pipe_data   <= msg1_data;
        end else if (msg3_ready) begin
            if (msg1_valid) begin
                starve_cnt <= starve_hit ? starve_cnt : starve_cnt + 4'd1;
            end else begin
                starve_cnt <= '0;
            end
            pipe_chan   <= 1'b1;
            pipe_type   <= msg3_type;
            pipe_source <= msg3_source;
            pipe_tag    <= msg3_tag;
            pipe_data   <= msg3_data;
        end
    end

    // Two-entry shift queue: head always drives msg2_type, vacated slots are zeroed.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_count <= '0;
            q_head  <= '0;
            q_tail  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (q_count == 2'd0) q_head <= rsp_type;
                    else                 q_tail <= rsp_type;
                    q_count <= q_count + 2'd1;
                end
                2'b01: begin
                    q_head  <= q_tail;
                    q_tail  <= '0;
                    q_count <= q_count - 2'd1;
                end
                2'b11: begin
                    if (q_count == 2'd1) begin
                        q_head <= rsp_type;
                    end else begin
                        q_head <= q_tail;
                        q_tail <= rsp_type;
                    end
                end
                default: ;
            endcase
        end
    end

    assign msg2_valid = (q_count != 2'd0);
    assign msg2_type  = q_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            msg2_stall_cnt <= '0;
        end else if (pop) begin
            msg2_stall_cnt <= '0;
        end else if (msg2_valid && msg2_stall_cnt != 8'hFF) begin
            msg2_stall_cnt <= msg2_stall_cnt + 8'd1;
        end
    end

    assign sched_state = state;

endmodule

// File: tb/tb_l2_msg_sched.sv
// Randomized bench for l2_msg_sched: a transaction-level model predicts every
// handshake and output each cycle; directed phases hit arbitration, stall and reset corners.
module tb_l2_msg_sched;

    localparam int DATA_W     = 64;
    localparam int TAG_W      = 26;
    localparam int SRC_W      = 6;
    localparam int TYPE_W     = 8;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              msg1_valid = 1'b0, msg1_ready;
    logic [TYPE_W-1:0] msg1_type = '0;
    logic [SRC_W-1:0]  msg1_source = '0;
    logic [TAG_W-1:0]  msg1_tag = '0;
    logic [DATA_W-1:0] msg1_data = '0;
    logic              msg3_valid = 1'b0, msg3_ready;
    logic [TYPE_W-1:0] msg3_type = '0;
    logic [SRC_W-1:0]  msg3_source = '0;
    logic [TAG_W-1:0]  msg3_tag = '0;
    logic [DATA_W-1:0] msg3_data = '0;
    logic              pipe_valid, pipe_ready = 1'b0, pipe_chan;
    logic [TYPE_W-1:0] pipe_type;
    logic [SRC_W-1:0]  pipe_source;
    logic [TAG_W-1:0]  pipe_tag;
    logic [DATA_W-1:0] pipe_data;
    logic              rsp_valid = 1'b0, rsp_ready;
    logic [TYPE_W-1:0] rsp_type = '0;
    logic              msg2_valid, msg2_ready = 1'b0;
    logic [TYPE_W-1:0] msg2_type;
    logic [7:0]        msg2_stall_cnt;
    logic [1:0]        sched_state;

    l2_msg_sched #(
        .DATA_W(DATA_W), .TAG_W(TAG_W), .SRC_W(SRC_W),
        .TYPE_W(TYPE_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .msg1_valid(msg1_valid), .msg1_ready(msg1_ready), .msg1_type(msg1_type),
        .msg1_source(msg1_source), .msg1_tag(msg1_tag), .msg1_data(msg1_data),
        .msg3_valid(msg3_valid), .msg3_ready(msg3_ready), .msg3_type(msg3_type),
        .msg3_source(msg3_source), .msg3_tag(msg3_tag), .msg3_data(msg3_data),
        .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_chan(pipe_chan),
        .pipe_type(pipe_type), .pipe_source(pipe_source), .pipe_tag(pipe_tag),
        .pipe_data(pipe_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_type(rsp_type),
        .msg2_valid(msg2_valid), .msg2_ready(msg2_ready), .msg2_type(msg2_type),
        .msg2_stall_cnt(msg2_stall_cnt), .sched_state(sched_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus knobs, in percent
    int  p1 = 50, p3 = 50, ppipe = 50, prsp = 50, pm2 = 50, pzero = 20;
    bit  rst_req = 1'b1;
    bit  log_grants = 1'b0;
    int  dut_grants[$];

    // Reference model: one held message, whether the pipe took it, and the msg2 FIFO
    bit                m_held, m_taken;
    logic              m_chan;
    logic [TYPE_W-1:0] m_type;
    logic [SRC_W-1:0]  m_source;
    logic [TAG_W-1:0]  m_tag;
    logic [DATA_W-1:0] m_data;
    int                m_starve, m_stall;
    logic [TYPE_W-1:0] mq[$];
    bit                h1, h3, hpipe, hrsp, hm2;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_held = 0; m_taken = 0; m_chan = 0; m_type = '0; m_source = '0;
        m_tag = '0; m_data = '0; m_starve = 0; m_stall = 0; mq.delete();
    endtask

    task automatic applyStimulus();
        rst         = rst_req;
        msg1_valid  = int'($urandom_range(99)) < p1;
        msg1_type   = 8'($urandom);
        msg1_source = 6'($urandom);
        msg1_tag    = 26'($urandom);
        msg1_data   = {$urandom, $urandom};
        msg3_valid  = int'($urandom_range(99)) < p3;
        msg3_type   = 8'($urandom);
        msg3_source = 6'($urandom);
        msg3_tag    = 26'($urandom);
        msg3_data   = {$urandom, $urandom};
        pipe_ready  = int'($urandom_range(99)) < ppipe;
        rsp_valid   = int'($urandom_range(99)) < prsp;
        rsp_type    = (int'($urandom_range(99)) < pzero) ? 8'h00 : 8'($urandom_range(255, 1));
        msg2_ready  = int'($urandom_range(99)) < pm2;
    endtask

    // Predict this cycle's outputs from the model and the driven inputs, then compare
    task automatic checkCycle();
        bit e1, e3, epv, err;
        int est;
        e1 = 0; e3 = 0;
        if (!m_held) begin
            if (msg1_valid && msg3_valid) begin
                if (m_starve == STARVE_MAX) e1 = 1; else e3 = 1;
            end else begin
                e1 = msg1_valid;
                e3 = msg3_valid;
            end
        end
        epv = m_held && !m_taken;
        err = m_held && m_taken && (mq.size() < 2);
        est = !m_held ? 0 : (!m_taken ? 1 : 2);
        checkOutput("msg1_ready", 64'(msg1_ready), 64'(e1));
        checkOutput("msg3_ready", 64'(msg3_ready), 64'(e3));
        checkOutput("pipe_valid", 64'(pipe_valid), 64'(epv));
        checkOutput("pipe_chan", 64'(pipe_chan), 64'(m_chan));
        checkOutput("pipe_type", 64'(pipe_type), 64'(m_type));
        checkOutput("pipe_source", 64'(pipe_source), 64'(m_source));
        checkOutput("pipe_tag", 64'(pipe_tag), 64'(m_tag));
        checkOutput("pipe_data", pipe_data, m_data);
        checkOutput("rsp_ready", 64'(rsp_ready), 64'(err));
        checkOutput("msg2_valid", 64'(msg2_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) checkOutput("msg2_type", 64'(msg2_type), 64'(mq[0]));
        checkOutput("stall_cnt", 64'(msg2_stall_cnt), 64'(m_stall));
        checkOutput("sched_state", 64'(sched_state), 64'(est));
        if (log_grants && msg1_valid && msg1_ready) dut_grants.push_back(1);
        if (log_grants && msg3_valid && msg3_ready) dut_grants.push_back(3);
        h1    = e1;
        h3    = e3;
        hpipe = epv && pipe_ready;
        hrsp  = err && rsp_valid;
        hm2   = (mq.size() != 0) && msg2_ready;
    endtask

    task automatic updateModel();
        if (rst) begin
            modelReset();
            return;
        end
        if (hm2) begin
            void'(mq.pop_front());
            m_stall = 0;
        end else if (mq.size() != 0) begin
            m_stall = (m_stall < 255) ? m_stall + 1 : 255;
        end
        if (h1 || h3) begin
            m_held = 1; m_taken = 0;
            m_chan   = h3;
            m_type   = h3 ? msg3_type   : msg1_type;
            m_source = h3 ? msg3_source : msg1_source;
            m_tag    = h3 ? msg3_tag    : msg1_tag;
            m_data   = h3 ? msg3_data   : msg1_data;
            if (h3 && msg1_valid) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
            else                  m_starve = 0;
        end
        if (hpipe) m_taken = 1;
        if (hrsp) begin
            m_held = 0; m_taken = 0;
            if (rsp_type != 8'h00) mq.push_back(rsp_type);
        end
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus();
            @(negedge clk);
            checkCycle();
            @(posedge clk);
            updateModel();
            #1;
        end
    endtask

    task automatic setKnobs(input int a1, input int a3, input int ap, input int ar,
                            input int am, input int az);
        p1 = a1; p3 = a3; ppipe = ap; prsp = ar; pm2 = am; pzero = az;
    endtask

    task automatic pulseReset();
        setKnobs(0, 0, 0, 0, 0, 0);
        rst_req = 1'b1;
        runCycles(2);
        rst_req = 1'b0;
    endtask

    initial begin : main
        int expected_order[10];
        bool_loop : begin end
        expected_order = '{3, 3, 3, 3, 1, 3, 3, 3, 3, 1};
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        pulseReset();

        // Mixed random traffic
        setKnobs(50, 50, 60, 60, 50, 20);
        runCycles(1500);

        // Starvation guard with both channels always requesting
        pulseReset();
        setKnobs(100, 100, 100, 100, 100, 0);
        log_grants = 1'b1;
        runCycles(40);
        log_grants = 1'b0;
        checkOutput("grant_count", 64'(dut_grants.size() >= 10), 64'd1);
        for (int i = 0; i < 10 && i < dut_grants.size(); i++)
            checkOutput($sformatf("grant_order[%0d]", i), 64'(dut_grants[i]), 64'(expected_order[i]));

        // Long msg2 stall saturates the counter, then drains
        pulseReset();
        setKnobs(100, 0, 100, 100, 0, 0);
        runCycles(300);
        checkOutput("stall_sat", 64'(msg2_stall_cnt), 64'd255);
        checkOutput("queue_full_rsp_ready", 64'(rsp_ready), 64'd0);
        setKnobs(0, 0, 100, 100, 100, 0);
        runCycles(10);

        // Reset while a message is in ISSUE and one msg2 entry is queued
        pulseReset();
        setKnobs(100, 0, 100, 100, 0, 0);
        begin
            bit reached = 0;
            for (int i = 0; i < 50 && !reached; i++) begin
                runCycles(1);
                if (m_held && !m_taken && mq.size() == 1) reached = 1;
            end
            checkOutput("reach_issue_queued", 64'(reached), 64'd1);
        end
        setKnobs(0, 0, 0, 0, 0, 0);
        rst_req = 1'b1;
        runCycles(1);
        rst_req = 1'b0;
        checkOutput("rst_state", 64'(sched_state), 64'd0);
        checkOutput("rst_pipe_valid", 64'(pipe_valid), 64'd0);
        checkOutput("rst_msg2_valid", 64'(msg2_valid), 64'd0);
        checkOutput("rst_stall_cnt", 64'(msg2_stall_cnt), 64'd0);
        runCycles(3);

        // Random traffic rich in no-response types and backpressure
        setKnobs(40, 40, 50, 70, 30, 50);
        runCycles(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_msg_sched.md
# l2_msg_sched

Message scheduler in front of the PMESH L2 pipeline. It arbitrates the msg1 (new request) and msg3 (response/ack) input channels into a single in-flight message. It presents that message to the L2 pipeline and buffers pipeline responses into a 2-entry queue that drives the msg2 output channel under msg2 backpressure. One message is in flight at a time, matching the single cur_msg register of the L2 model.

## Interface
Parameters:
- DATA_W, 64, message data width
- TAG_W, 26, cache tag width
- SRC_W, 6, source/owner id width
- TYPE_W, 8, message type width
- STARVE_MAX, 4, consecutive msg3 grants allowed while msg1 waits (1..15)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous reset, active-high
- msg1_valid / msg1_ready  in / out  1  request channel handshake
- msg1_type / msg1_source / msg1_tag / msg1_data  in  TYPE_W / SRC_W / TAG_W / DATA_W  request payload
- msg3_valid / msg3_ready, msg3_type / msg3_source / msg3_tag / msg3_data  same as msg1, response channel
- pipe_valid  out  1  held message presented to L2 pipeline
- pipe_ready  in  1  pipeline accepts
- pipe_chan  out  1  0 = msg from msg1, 1 = from msg3
- pipe_type / pipe_source / pipe_tag / pipe_data  out  held payload
- rsp_valid / rsp_ready  in / out  1  pipeline result handshake
- rsp_type  in  TYPE_W  outgoing msg2 type; 0x00 = no msg2 to emit
- msg2_valid / msg2_ready  out / in  1  output channel handshake
- msg2_type  out  TYPE_W  head of msg2 queue
- msg2_stall_cnt  out  8  saturating msg2 stall counter
- sched_state  out  2  FSM state (debug)

## Operation
- FSM: IDLE(0), ISSUE(1), WAIT_RSP(2); encoding 3 unused and returns to IDLE.
- IDLE: grant arbitration, combinational on current inputs.
  - Only msg1_valid: msg1 granted.
  - Only msg3_valid: msg3 granted.
  - Both valid: msg3 granted, unless starve_cnt == STARVE_MAX, in which case msg1 is granted.
- Ready signals: msg1_ready / msg3_ready are high only in IDLE and only for the granted channel; at most one is high per cycle.
- Input handshake: captures payload and channel into the held registers; next state ISSUE.
- starve_cnt (4-bit), updated on each grant:
  - msg3 grant while msg1_valid: +1, saturating at STARVE_MAX.
  - msg1 grant, or msg3 grant without msg1_valid: cleared to 0.
- ISSUE: pipe_valid = 1 with held fields stable. When pipe_ready is high, next state is WAIT_RSP.
- WAIT_RSP: rsp_ready = (q_count < 2). On rsp handshake:
  - rsp_type != 0: push rsp_type into the msg2 queue.
  - rsp_type == 0: no push.
  - Next state IDLE in both cases.
- msg2 queue: 2 entries, FIFO order.
  - msg2_valid = (q_count != 0); msg2_type = head entry.
  - Pop on msg2_valid && msg2_ready.
  - Push and pop in the same cycle: q_count is unchanged and order is preserved.
- msg2_stall_cnt:
  - Cleared to 0 on a msg2 handshake.
  - Otherwise incremented when msg2_valid && !msg2_ready, saturating at 255.
  - Otherwise held.

## Timing
- Reset values:
  - sched_state = IDLE, starve_cnt = 0, q_count = 0, msg2_stall_cnt = 0.
  - msg1_ready, msg3_ready, pipe_valid, rsp_ready, msg2_valid all 0.
  - All held payload registers and msg2_type are 0.
- Reset mid-operation drops the held message and all queued msg2 entries; no output asserts in the cycle after rst.
- Minimum round trip, with the input handshake in cycle N:
  - pipe_valid high at N+1; pipe_ready at N+1 gives WAIT_RSP at N+2.
  - rsp handshake at N+2 gives msg2_valid at N+3, with sched_state IDLE at N+3.
  - Next input ready at N+3.
- pipe_valid stays asserted until accepted. Payload must not change while pipe_valid && !pipe_ready.
- msg2_type is stable while msg2_valid && !msg2_ready. Queue full (q_count = 2) drops rsp_ready to 0 and blocks the FSM in WAIT_RSP.
- Inputs arriving outside IDLE see ready = 0 and are not consumed.

## Test plan
- Single msg1 (type 0x01, tag 0x123, src 5), pipe_ready = 1, rsp_type 0x0A, msg2_ready = 1 → pipe fields match at N+1; msg2_valid with 0x0A at N+3; msg2_stall_cnt stays 0.
- msg1 and msg3 both continuously valid, STARVE_MAX = 4 → grant order: 3,3,3,3,1,3,3,3,3,1.
- msg2_ready = 0, three responses with types 0x11, 0x22, 0x33:
  - q_count reaches 2 and rsp_ready = 0 while the third response waits.
  - Then release msg2_ready → output order 0x11, 0x22, 0x33.
- msg2 held stalled for 300 cycles → msg2_stall_cnt saturates at 255; the handshake cycle clears it to 0 on the next cycle.
- rsp_type 0x00 → FSM returns to IDLE; msg2_valid stays 0.
- rst asserted while in ISSUE with 1 entry queued → next cycle: sched_state 0, pipe_valid 0, msg2_valid 0, all counters 0.
